cpa_share_ctrl: RTL

- Time-shares one external W-bit carry-propagate adder (CPA) among NUM_REQ requesters using round-robin arbitration and valid/ready handshakes.
- The CPA has ports a, b, sum and cout, and no carry-in.
- Each request is either narrow (W-bit add) or wide (2W-bit add).
- A wide add is sequenced as a low pass, a high pass and, when needed, a carry-fix pass. This block sits between the multiplier post-processing requesters and the shared prefix CPA.

---
 rtl/cpa_share_pkg.sv | 24 ++
 rtl/rr_arbiter_pick.sv | 30 +++
 rtl/cpa_share_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cpa_share_pkg.sv
// Shared types and helpers for the time-shared CPA controller.
// State encoding and the id-width helper used by the top.
package cpa_share_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    FIX  = 3'd3,
    RSP  = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr,
// wrapping around; returns a one-hot grant and its index.
module rr_arbiter_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] j;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/cpa_share_ctrl.sv
// Shares one W-bit CPA among NUM_REQ requesters; wide adds run as
// low pass, high pass and an optional carry-fix pass.
module cpa_share_ctrl
  import cpa_share_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int W       = 16,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_wide,
  input  logic [NUM_REQ*2*W-1:0] req_a,
  input  logic [NUM_REQ*2*W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*W-1:0]         rsp_sum,
  output logic                   rsp_cout,
  output logic [W-1:0]           cpa_a,
  output logic [W-1:0]           cpa_b,
  input  logic [W-1:0]           cpa_sum,
  input  logic                   cpa_cout,
  output logic                   busy
);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            wide_q, wide_d;
  logic [W-1:0]    hi_a_q, hi_a_d;
  logic [W-1:0]    hi_b_q, hi_b_d;
  logic [W-1:0]    sum_lo_q, sum_lo_d;
  logic            c_lo_q, c_lo_d;
  logic            c_hi_q, c_hi_d;
  logic [W-1:0]    cpa_a_q, cpa_a_d;
  logic [W-1:0]    cpa_b_q, cpa_b_d;
  logic [2*W-1:0]  sum_q, sum_d;
  logic            cout_q, cout_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    pick;
  logic [2*W-1:0]     a_sel, b_sel;
  logic               wide_sel;
  logic               any;

  rr_arbiter_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (pick)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*2*W +: 2*W];
        b_sel = req_b[i*2*W +: 2*W];
      end
    end
  end

  assign wide_sel = |(gnt & req_wide);
  assign any      = |gnt;

  // Grants are suppressed while rst is high so no handshake is lost.
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign rsp_valid = (state_q == RSP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign cpa_a     = cpa_a_q;
  assign cpa_b     = cpa_b_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    wide_d   = wide_q;
    hi_a_d   = hi_a_q;
    hi_b_d   = hi_b_q;
    sum_lo_d = sum_lo_q;
    c_lo_d   = c_lo_q;
    c_hi_d   = c_hi_q;
    cpa_a_d  = cpa_a_q;
    cpa_b_d  = cpa_b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          id_d    = pick;
          wide_d  = wide_sel;
          hi_a_d  = a_sel[2*W-1:W];
          hi_b_d  = b_sel[2*W-1:W];
          cpa_a_d = a_sel[W-1:0];
          cpa_b_d = b_sel[W-1:0];
          ptr_d   = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);
          state_d = LO;
        end
      end
      LO: begin
        sum_lo_d = cpa_sum;
        c_lo_d   = cpa_cout;
        if (wide_q) begin
          cpa_a_d = hi_a_q;
          cpa_b_d = hi_b_q;
          state_d = HI;
        end else begin
          sum_d   = {{W{1'b0}}, cpa_sum};
          cout_d  = cpa_cout;
          state_d = RSP;
        end
      end
      HI: begin
        c_hi_d = cpa_cout;
        // Low-half carry is folded in with a +1 pass on the high sum.
        if (c_lo_q) begin
          cpa_a_d = cpa_sum;
          cpa_b_d = W'(1);
          state_d = FIX;
        end else begin
          sum_d   = {cpa_sum, sum_lo_q};
          cout_d  = cpa_cout;
          state_d = RSP;
        end
      end
      FIX: begin
        sum_d   = {cpa_sum, sum_lo_q};
        cout_d  = c_hi_q | cpa_cout;
        state_d = RSP;
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      wide_q   <= 1'b0;
      hi_a_q   <= '0;
      hi_b_q   <= '0;
      sum_lo_q <= '0;
      c_lo_q   <= 1'b0;
      c_hi_q   <= 1'b0;
      cpa_a_q  <= '0;
      cpa_b_q  <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      wide_q   <= wide_d;
      hi_a_q   <= hi_a_d;
      hi_b_q   <= hi_b_d;
      sum_lo_q <= sum_lo_d;
      c_lo_q   <= c_lo_d;
      c_hi_q   <= c_hi_d;
      cpa_a_q  <= cpa_a_d;
      cpa_b_q  <= cpa_b_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

endmodule
